// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back formatter.
// This block is the only producer of the register-file write port. It captures
// the retiring instruction and selects the ALU, load or PC+4 result. It also
// sign- or zero-extends sub-word loads and drops writes to x0. It exposes a
// forwarding tap and counts retired instructions.

// Sub-word load extraction plus alignment check for one load word.
module wb_load_fmt #(
  parameter int width = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [width-1:0] word,
  output logic [width-1:0] data,
  output logic             misaligned
);

  logic [width-1:0] bsh;
  logic [width-1:0] hsh;
  logic [7:0]       b;
  logic [15:0]      h;

  // Byte lane picked by the full offset, halfword lane picked by offset bit 1.
  always_comb begin
    bsh = word >> {off, 3'b000};
    hsh = word >> {off[1], 4'b0000};
    b   = bsh[7:0];
    h   = hsh[15:0];
  end

  // Extension per load type; unknown encodings fall back to a word load.
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      3'b000: data = {{(width-8){b[7]}}, b};
      3'b100: data = {{(width-8){1'b0}}, b};
      3'b001: begin
        data       = {{(width-16){h[15]}}, h};
        misaligned = off[0];
      end
      3'b101: begin
        data       = {{(width-16){1'b0}}, h};
        misaligned = off[0];
      end
      default: begin
        data       = word;
        misaligned = |off;
      end
    endcase
  end

endmodule

module writeback_stage #(
  parameter int width     = 32,
  parameter int addrWidth = 5,
  parameter int cntWidth  = 64
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_reg_write,
  input  logic [addrWidth-1:0] in_rd,
  input  logic [1:0]           in_wb_sel,
  input  logic [2:0]           in_funct3,
  input  logic [width-1:0]     in_alu_result,
  input  logic [width-1:0]     in_pc_plus4,
  input  logic [width-1:0]     mem_rdata,
  output logic                 regWriteEnable,
  output logic [addrWidth-1:0] addrD,
  output logic [width-1:0]     dataD,
  output logic                 fwd_valid,
  output logic [addrWidth-1:0] fwd_rd,
  output logic [width-1:0]     fwd_data,
  output logic                 misalign_err,
  output logic [cntWidth-1:0]  instret
);

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 reg_write;
    logic [addrWidth-1:0] rd;
    logic [1:0]           wb_sel;
    logic [2:0]           funct3;
    logic [width-1:0]     alu;
    logic [width-1:0]     pc4;
    logic [width-1:0]     rdata;
  } stage_t;

  stage_t           st;
  logic             fire;
  logic             is_load;
  logic             mis;
  logic             wr_ok;
  logic [width-1:0] ld_data;
  logic             ld_mis;
  logic [width-1:0] result;

  wb_load_fmt #(.width(width)) u_fmt (
    .funct3     (st.funct3),
    .off        (st.alu[1:0]),
    .word       (st.rdata),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  // Stage register. Reset beats flush, and flush beats stall. The done flag
  // marks an entry that has already written, so a stall cannot repeat it.
  always_ff @(posedge clock) begin
    if (!clear) begin
      st <= '0;
    end else if (flush) begin
      st.valid <= 1'b0;
      st.done  <= 1'b0;
    end else if (stall) begin
      st.done <= st.valid;
    end else begin
      st.valid     <= in_valid;
      st.done      <= 1'b0;
      st.reg_write <= in_reg_write;
      st.rd        <= in_rd;
      st.wb_sel    <= in_wb_sel;
      st.funct3    <= in_funct3;
      st.alu       <= in_alu_result;
      st.pc4       <= in_pc_plus4;
      st.rdata     <= mem_rdata;
    end
  end

  // Result selection and write qualification for the held entry.
  always_comb begin
    fire    = st.valid & ~st.done;
    is_load = (st.wb_sel == 2'b01);
    mis     = is_load & ld_mis;
    wr_ok   = st.reg_write & (st.rd != '0) & ~mis;
    case (st.wb_sel)
      2'b01:   result = ld_data;
      2'b10:   result = st.pc4;
      default: result = st.alu;
    endcase
  end

  // Output port mapping; forwarding stays up through stalls, the write does not.
  always_comb begin
    regWriteEnable = fire & wr_ok;
    addrD          = st.rd;
    dataD          = result;
    fwd_valid      = st.valid & wr_ok;
    fwd_rd         = st.rd;
    fwd_data       = result;
    misalign_err   = fire & mis;
  end

  // Count every first WB cycle, whether or not it writes; wraps naturally.
  always_ff @(posedge clock) begin
    if (!clear)    instret <= '0;
    else if (fire) instret <= instret + 1'b1;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage. A per-entry behavioural model is checked
// on every cycle, and hand-computed literals pin the key scenarios.
module tb_writeback_stage;

  logic        clock = 1'b0;
  logic        clear, stall, flush, in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_pc_plus4, mem_rdata;
  logic        regWriteEnable, fwd_valid, misalign_err;
  logic [4:0]  addrD, fwd_rd;
  logic [31:0] dataD, fwd_data;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  writeback_stage dut (
    .clock(clock), .clear(clear), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_pc_plus4(in_pc_plus4), .mem_rdata(mem_rdata),
    .regWriteEnable(regWriteEnable), .addrD(addrD), .dataD(dataD),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .instret(instret)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model of a load result, written in plain arithmetic terms.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] w);
    int unsigned off, bv, hv;
    off = addr % 4;
    bv  = (w >> (8 * off)) % 256;
    hv  = (w >> (16 * (off / 2))) % 65536;
    case (f3)
      3'd0:    return (bv >= 128) ? (32'hFFFF_FF00 | bv) : bv;
      3'd4:    return bv;
      3'd1:    return (hv >= 32768) ? (32'hFFFF_0000 | hv) : hv;
      3'd5:    return hv;
      default: return w;
    endcase
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off;
    off = addr % 4;
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
    return off != 0;
  endfunction

  // Model state: the entry being written back plus the retirement count.
  bit          m_started = 0;
  bit          m_valid, m_written, m_rw, m_mis;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [63:0] m_cnt;

  always @(posedge clock) begin
    if (!clear) begin
      m_started = 1; m_valid = 0; m_written = 0; m_rw = 0; m_mis = 0;
      m_rd = 0; m_data = 0; m_cnt = 0;
    end else if (m_started) begin
      if (m_valid && !m_written) m_cnt = m_cnt + 1;
      if (flush) begin
        m_valid = 0; m_written = 0;
      end else if (stall) begin
        if (m_valid) m_written = 1;
      end else begin
        m_valid = in_valid; m_written = 0; m_rw = in_reg_write; m_rd = in_rd;
        m_mis   = (in_wb_sel == 2'd1) && m_misal(in_funct3, in_alu_result);
        if (in_wb_sel == 2'd1)      m_data = m_load(in_funct3, in_alu_result, mem_rdata);
        else if (in_wb_sel == 2'd2) m_data = in_pc_plus4;
        else                        m_data = in_alu_result;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (m_started) begin
      bit fire, ok;
      fire = m_valid && !m_written;
      ok   = m_rw && (m_rd != 0) && !m_mis;
      chk("m_we",    regWriteEnable, fire && ok);
      chk("m_addrD", addrD,          m_rd);
      chk("m_dataD", dataD,          m_data);
      chk("m_fwdv",  fwd_valid,      m_valid && ok);
      chk("m_fwdrd", fwd_rd,         m_rd);
      chk("m_fwdd",  fwd_data,       m_data);
      chk("m_mis",   misalign_err,   fire && m_mis);
      chk("m_cnt",   instret,        m_cnt);
    end
  end

  // Apply one cycle of inputs, then wait for the sampling edge.
  task automatic put(input logic cl, input logic s, input logic f, input logic v,
                     input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                     input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                     input logic [31:0] w);
    #1;
    clear = cl; stall = s; flush = f; in_valid = v; in_reg_write = rw; in_rd = rd;
    in_wb_sel = sel; in_funct3 = f3; in_alu_result = alu; in_pc_plus4 = pc4; mem_rdata = w;
    @(negedge clock);
  endtask

  task automatic lit(input string n, input logic we, input logic [31:0] d,
                     input logic fv, input logic me, input logic [63:0] cnt);
    chk({n, "_we"},  regWriteEnable, we);
    chk({n, "_d"},   dataD,          d);
    chk({n, "_fv"},  fwd_valid,      fv);
    chk({n, "_me"},  misalign_err,   me);
    chk({n, "_cnt"}, instret,        cnt);
  endtask

  typedef struct { logic [1:0] sel; logic [2:0] f3; logic [31:0] alu; logic [31:0] d; logic we; } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'd1, 3'd4, 32'h3,   32'h0000_0087, 1'b1};
    tbl[1] = '{2'd1, 3'd0, 32'h0,   32'hFFFF_FFA1, 1'b1};
    tbl[2] = '{2'd1, 3'd1, 32'h0,   32'h0000_43A1, 1'b1};
    tbl[3] = '{2'd1, 3'd1, 32'h2,   32'hFFFF_8765, 1'b1};
    tbl[4] = '{2'd1, 3'd5, 32'h2,   32'h0000_8765, 1'b1};
    tbl[5] = '{2'd1, 3'd3, 32'h0,   32'h8765_43A1, 1'b1};
    tbl[6] = '{2'd1, 3'd1, 32'h1,   32'h0000_6543, 1'b0};
    tbl[7] = '{2'd2, 3'd0, 32'h10,  32'h0000_0104, 1'b1};
    tbl[8] = '{2'd3, 3'd0, 32'hABC, 32'h0000_0ABC, 1'b1};

    clear = 0; stall = 0; flush = 0; in_valid = 0; in_reg_write = 0; in_rd = 0;
    in_wb_sel = 0; in_funct3 = 0; in_alu_result = 0; in_pc_plus4 = 0; mem_rdata = 0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lit("rst", 0, 0, 0, 0, 0);
    chk("rst_addr", addrD, 0);

    // LB off=1 from 1234_80FF.
    put(1, 0, 0, 1, 1, 5, 1, 3'd0, 32'h1, 32'h0, 32'h1234_80FF);
    lit("lb", 1, 32'hFFFF_FF80, 1, 0, 0);
    chk("lb_addr", addrD, 5);
    // LHU off=2, then misaligned LW.
    put(1, 0, 0, 1, 1, 7, 1, 3'd5, 32'h2, 32'h0, 32'h1234_80FF);
    lit("lhu", 1, 32'h0000_1234, 1, 0, 1);
    put(1, 0, 0, 1, 1, 8, 1, 3'd2, 32'h2, 32'h0, 32'h1234_80FF);
    lit("lw_mis", 0, 32'h1234_80FF, 0, 1, 2);
    // ALU to x0.
    put(1, 0, 0, 1, 1, 0, 0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    lit("x0", 0, 32'hDEAD_BEEF, 0, 0, 3);
    // ALU rd=3 followed by a three-cycle stall.
    put(1, 0, 0, 1, 1, 3, 0, 3'd0, 32'h55, 32'h0, 32'h0);
    lit("alu3", 1, 32'h55, 1, 0, 4);
    for (int i = 0; i < 3; i++) begin
      put(1, 1, 0, 1, 1, 9, 0, 3'd0, 32'h99, 32'h0, 32'h0);
      lit("stall", 0, 32'h55, 1, 0, 5);
    end
    put(1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
    lit("bub", 0, 32'h0, 0, 0, 5);
    // Stall then stall+flush: bubble without an extra count.
    put(1, 0, 0, 1, 1, 9, 0, 3'd0, 32'h99, 32'h0, 32'h0);
    lit("alu9", 1, 32'h99, 1, 0, 5);
    put(1, 1, 0, 1, 1, 1, 0, 3'd0, 32'h1, 32'h0, 32'h0);
    lit("alu9s", 0, 32'h99, 1, 0, 6);
    put(1, 1, 1, 1, 1, 1, 0, 3'd0, 32'h1, 32'h0, 32'h0);
    lit("sflush", 0, 32'h99, 0, 0, 6);
    chk("sflush_addr", addrD, 9);
    // Reset in the middle of a stall.
    put(1, 0, 0, 1, 1, 10, 0, 3'd0, 32'h77, 32'h0, 32'h0);
    lit("alu10", 1, 32'h77, 1, 0, 6);
    put(1, 1, 0, 1, 1, 10, 0, 3'd0, 32'h77, 32'h0, 32'h0);
    lit("alu10s", 0, 32'h77, 1, 0, 7);
    put(0, 1, 0, 1, 1, 10, 0, 3'd0, 32'h77, 32'h0, 32'h0);
    lit("midrst", 0, 32'h0, 0, 0, 0);
    chk("midrst_addr", addrD, 0);
    put(1, 1, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
    lit("postrst", 0, 32'h0, 0, 0, 0);

    // Load-format and result-select table, issued back to back.
    foreach (tbl[i]) begin
      put(1, 0, 0, 1, 1, 5'(i + 1), tbl[i].sel, tbl[i].f3, tbl[i].alu, 32'h104, 32'h8765_43A1);
      chk($sformatf("tbl%0d_we", i), regWriteEnable, tbl[i].we);
      if (tbl[i].we) chk($sformatf("tbl%0d_d", i), dataD, tbl[i].d);
      chk($sformatf("tbl%0d_cnt", i), instret, 64'(i));
    end
    put(1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
    chk("final_cnt", instret, 9);
    put(1, 0, 0, 0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
